// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, req/ready fetch handshake,
// skid buffer for stall-time responses and priority redirect (interrupt > branch > jump).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INT_PC   = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        intterupt,
  input  logic        JumpID,
  input  logic [31:0] jumptargetID,
  input  logic        BranchTakenEX,
  input  logic [31:0] branchtargetEX,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instructionID,
  output logic [31:0] pcplus4ID,
  output logic        validID,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {StIdle, StFetch, StHeld, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q, epc_d;

  logic        transfer;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign imem_req      = (state_q == StFetch) || (state_q == StDrop);
  // While dropping, the outstanding request must stay at the wrong-path address.
  assign imem_addr     = (state_q == StDrop) ? drop_addr_q : pc_q;
  assign transfer      = imem_req & imem_ready;
  assign redirect      = intterupt | BranchTakenEX | JumpID;
  assign pc_plus4      = pc_q + 32'd4;

  assign instructionID = instr_q;
  assign pcplus4ID     = pc4_q;
  assign validID       = valid_q;
  assign epc           = epc_q;

  always_comb begin
    target = jumptargetID;
    if (intterupt) begin
      target = INT_PC;
    end else if (BranchTakenEX) begin
      target = branchtargetEX;
    end
    target[1:0] = 2'b00;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    skid_d      = skid_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    epc_d       = epc_q;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (transfer) begin
          pc_d = pc_plus4;
          if (stall) begin
            skid_d  = imem_rdata;
            state_d = StHeld;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      StHeld: begin
        if (!stall) begin
          // pc already advanced past the buffered word, so it is that word's PC+4.
          instr_d = skid_q;
          pc4_d   = pc_q;
          valid_d = 1'b1;
          state_d = StFetch;
        end
      end
      StDrop: begin
        if (imem_ready) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase

    if (redirect) begin
      pc_d    = target;
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
      skid_d  = 32'h0;
      unique case (state_q)
        StFetch: begin
          if (!transfer) begin
            state_d     = StDrop;
            drop_addr_d = pc_q;
          end else begin
            state_d = StFetch;
          end
        end
        StDrop:  state_d = imem_ready ? StFetch : StDrop;
        default: state_d = StFetch;
      endcase
      if (intterupt) epc_d = valid_q ? (pc4_q - 32'd4) : pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0;
      skid_q      <= 32'h0;
      instr_q     <= 32'h0;
      pc4_q       <= 32'h0;
      valid_q     <= 1'b0;
      epc_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      skid_q      <= skid_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      epc_q       <= epc_d;
    end
  end

endmodule
